// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 16 requesters with a registered valid/ready grant output.
// The winner is emitted as a binary index for the downstream 4-to-16 decoder.
module rr_grant_encoder #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [IDX_W-1:0]   ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic               grant_valid_reg, grant_valid_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;

  logic               accept;
  logic [IDX_W-1:0]   sel_start;
  logic [IDX_W-1:0]   sel_off;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] req_rot;

  assign accept = grant_valid_reg & out_ready;

  // On accept the search restarts just past the accepted index, which is also the new ptr.
  assign sel_start = accept ? grant_idx_reg + IDX_W'(1) : ptr_reg;

  // Mask the accepted requester, then rotate so sel_start lands at bit 0.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign req_masked[gi] = req[gi] & ~(accept & (grant_idx_reg == IDX_W'(gi)));
    assign req_rot[gi]    = req_masked[sel_start + IDX_W'(gi)];
  end

  always_comb begin
    sel_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_off = IDX_W'(i);
    end
  end

  assign sel_idx = sel_start + sel_off;
  assign sel_any = |req_masked;

  always_comb begin
    state_next       = state_reg;
    grant_valid_next = grant_valid_reg;
    grant_idx_next   = grant_idx_reg;
    ptr_next         = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          state_next       = OFFER;
          grant_valid_next = 1'b1;
          grant_idx_next   = sel_idx;
        end
      end
      OFFER: begin
        // Without accept the offer is held unchanged, whatever req does.
        if (accept) begin
          ptr_next = grant_idx_reg + IDX_W'(1);
          if (sel_any) begin
            grant_idx_next = sel_idx;
          end else begin
            state_next       = IDLE;
            grant_valid_next = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_valid_reg <= 1'b0;
      grant_idx_reg   <= '0;
      ptr_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      grant_valid_reg <= grant_valid_next;
      grant_idx_reg   <= grant_idx_next;
      ptr_reg         <= ptr_next;
    end
  end

  assign grant_valid = grant_valid_reg;
  assign grant_idx   = grant_idx_reg;
  assign ptr         = ptr_reg;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: expected grants go into a queue and a
// negedge monitor checks every accepted grant against it.
module tb_rr_grant_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        out_ready;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [3:0]  ptr;

  int exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  rr_grant_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .ptr         (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle where a grant is offered and accepted, compare with the scoreboard.
  always @(negedge clk) begin
    if (grant_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", int'(grant_idx), -1);
      end else begin
        check("accepted_grant_idx", int'(grant_idx), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with all requests asserted
    rst = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(grant_valid), 0);
    check("reset_idx",   int'(grant_idx),   0);
    check("reset_ptr",   int'(ptr),         0);

    // All 16 requesting, always ready: 0..15,0,1 back to back
    for (int i = 0; i < 18; i++) exp_q.push_back(i % 16);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    req = 16'h0000;
    tick();
    @(negedge clk);
    check("sweep_idle_valid", int'(grant_valid), 0);
    check("sweep_ptr",        int'(ptr),         2);

    // Single requester 5 with one-cycle latency
    exp_q.push_back(5);
    tick();
    req = 16'h0020;
    tick();
    req = 16'h0000;
    @(negedge clk);
    check("req5_valid", int'(grant_valid), 1);
    check("req5_idx",   int'(grant_idx),   5);
    tick();
    @(negedge clk);
    check("req5_idle_valid", int'(grant_valid), 0);
    check("req5_ptr",        int'(ptr),         6);

    // Reset, then stall a grant on req=8001
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 16'h8001; out_ready = 1'b0;
    @(negedge clk);
    check("rst2_ptr", int'(ptr), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("stall_valid", int'(grant_valid), 1);
      check("stall_idx",   int'(grant_idx),   0);
      check("stall_ptr",   int'(ptr),         0);
    end
    exp_q.push_back(0);
    exp_q.push_back(15);
    exp_q.push_back(0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    req = 16'h0000;
    tick();
    @(negedge clk);
    check("pair_idle_valid", int'(grant_valid), 0);
    check("pair_ptr",        int'(ptr),         1);

    // Grant 14 to move ptr to 15, then req[0] alone must wrap to 0
    exp_q.push_back(14);
    tick();
    req = 16'h4000;
    tick();
    req = 16'h0000;
    tick();
    @(negedge clk);
    check("wrap_pre_valid", int'(grant_valid), 0);
    check("wrap_pre_ptr",   int'(ptr),         15);
    exp_q.push_back(0);
    tick();
    req = 16'h0001;
    tick();
    req = 16'h0000;
    @(negedge clk);
    check("wrap_valid", int'(grant_valid), 1);
    check("wrap_idx",   int'(grant_idx),   0);
    tick();
    @(negedge clk);
    check("wrap_post_ptr", int'(ptr), 1);

    // Reset while offering grant 9 and stalled
    tick();
    out_ready = 1'b0; req = 16'h0200;
    tick();
    @(negedge clk);
    check("pre_rst_valid", int'(grant_valid), 1);
    check("pre_rst_idx",   int'(grant_idx),   9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(grant_valid), 0);
    check("mid_rst_ptr",   int'(ptr),         0);
    tick();
    @(negedge clk);
    check("regrant_valid", int'(grant_valid), 1);
    check("regrant_idx",   int'(grant_idx),   9);
    exp_q.push_back(9);
    tick();
    out_ready = 1'b1; req = 16'h0000;
    tick();
    @(negedge clk);
    check("regrant_ptr", int'(ptr), 10);

    // No requests: stay idle, ptr untouched
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("norq_valid", int'(grant_valid), 0);
      check("norq_ptr",   int'(ptr),         10);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
